mem_stage: RTL and testbench

- Pipeline stage directly downstream of execute, upstream of writeback.
- Accepts one instruction per give/get handshake from execute.
- Performs LOAD/STORE accesses on a single-outstanding data-memory port; passes every other instruction's result through unchanged.
- Delivers the instruction, pc and final data to writeback over the same give/get handshake.

---
 rtl/mem_stage_if.sv | 45 ++++
 rtl/mem_stage.sv | 182 ++++++++++++++++++
 tb/tb_mem_stage.sv | 259 +++++++++++++++++++++++++
 3 files changed

// File: rtl/mem_stage_if.sv
// Bundles the execute-side, data-memory and writeback-side signals of mem_stage.
// The slave modport is the stage's own view; master is the surrounding pipeline's view.
interface mem_stage_if #(
    parameter int BITSIZE = 32
);
    logic               EX_MEM_give_i;
    logic               MEM_EX_get_o;
    logic [31:0]        EX_MEM_instruction_i;
    logic [BITSIZE-1:0] EX_MEM_pc_i;
    logic [BITSIZE-1:0] EX_MEM_result_i;
    logic [BITSIZE-1:0] EX_MEM_rs2_i;

    logic               dmem_req_o;
    logic               dmem_we_o;
    logic [BITSIZE-1:0] dmem_addr_o;
    logic [3:0]         dmem_be_o;
    logic [BITSIZE-1:0] dmem_wdata_o;
    logic [BITSIZE-1:0] dmem_rdata_i;
    logic               dmem_valid_i;

    logic               MEM_WB_give_o;
    logic               WB_MEM_get_i;
    logic [31:0]        MEM_WB_instruction_o;
    logic [BITSIZE-1:0] MEM_WB_pc_o;
    logic [BITSIZE-1:0] MEM_WB_data_o;
    logic               MEM_WB_misaligned_o;

    modport slave (
        input  EX_MEM_give_i, EX_MEM_instruction_i, EX_MEM_pc_i, EX_MEM_result_i, EX_MEM_rs2_i,
        output MEM_EX_get_o,
        output dmem_req_o, dmem_we_o, dmem_addr_o, dmem_be_o, dmem_wdata_o,
        input  dmem_rdata_i, dmem_valid_i,
        output MEM_WB_give_o, MEM_WB_instruction_o, MEM_WB_pc_o, MEM_WB_data_o, MEM_WB_misaligned_o,
        input  WB_MEM_get_i
    );

    modport master (
        output EX_MEM_give_i, EX_MEM_instruction_i, EX_MEM_pc_i, EX_MEM_result_i, EX_MEM_rs2_i,
        input  MEM_EX_get_o,
        input  dmem_req_o, dmem_we_o, dmem_addr_o, dmem_be_o, dmem_wdata_o,
        output dmem_rdata_i, dmem_valid_i,
        input  MEM_WB_give_o, MEM_WB_instruction_o, MEM_WB_pc_o, MEM_WB_data_o, MEM_WB_misaligned_o,
        output WB_MEM_get_i
    );
endinterface

// File: rtl/mem_stage.sv
// Memory pipeline stage: performs aligned LOAD/STORE accesses on a single-outstanding
// data port and forwards every other instruction's result to writeback unchanged.
module mem_stage #(
    parameter int BITSIZE = 32
) (
    input  logic        clk,
    input  logic        resetn_i,
    mem_stage_if.slave  bus
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        REQ  = 2'd1,
        GIVE = 2'd2
    } state_t;

    localparam logic [6:0] OP_LOAD  = 7'b0000011;
    localparam logic [6:0] OP_STORE = 7'b0100011;

    state_t state_q, state_d;

    // Decode of the instruction currently offered by execute
    logic [6:0]         opcode;
    logic [2:0]         funct3;
    logic [1:0]         lane;
    logic               is_load;
    logic               is_store;
    logic               size_misaligned;
    logic               misaligned;
    logic               mem_access;
    logic [3:0]         be;
    logic [BITSIZE-1:0] wdata;
    logic [BITSIZE-1:0] accept_data;
    logic               accept;

    // Captured transaction
    logic [31:0]        instr_q;
    logic [BITSIZE-1:0] pc_q;
    logic [BITSIZE-1:0] data_q;
    logic               misaligned_q;
    logic               is_load_q;
    logic [2:0]         funct3_q;
    logic [1:0]         lane_q;
    logic               we_q;
    logic [BITSIZE-1:0] addr_q;
    logic [3:0]         be_q;
    logic [BITSIZE-1:0] wdata_q;

    logic [BITSIZE-1:0] rdata_shifted;
    logic [BITSIZE-1:0] load_data;

    assign accept = (state_q == IDLE) && bus.EX_MEM_give_i;

    // NOTE: every signal assigned in an always_comb gets a default before any branch,
    // so no path can leave it unassigned and infer a latch.
    always_comb begin
        opcode   = bus.EX_MEM_instruction_i[6:0];
        funct3   = bus.EX_MEM_instruction_i[14:12];
        lane     = bus.EX_MEM_result_i[1:0];
        is_load  = (opcode == OP_LOAD) &&
                   (funct3 inside {3'b000, 3'b001, 3'b010, 3'b100, 3'b101});
        is_store = (opcode == OP_STORE) && (funct3 inside {3'b000, 3'b001, 3'b010});

        size_misaligned = 1'b0;
        be              = 4'b1111;
        wdata           = bus.EX_MEM_rs2_i;
        // funct3[1:0] encodes access size for both loads and stores
        unique case (funct3[1:0])
            2'b00: begin
                be    = 4'b0001 << lane;
                wdata = {4{bus.EX_MEM_rs2_i[7:0]}};
            end
            2'b01: begin
                size_misaligned = lane[0];
                be              = 4'b0011 << lane;
                wdata           = {2{bus.EX_MEM_rs2_i[15:0]}};
            end
            default: begin
                size_misaligned = (lane != 2'b00);
            end
        endcase

        misaligned = (is_load || is_store) && size_misaligned;
        mem_access = (is_load || is_store) && !size_misaligned;

        // Loads fill data later; stores report their address; faults report zero
        accept_data = bus.EX_MEM_result_i;
        if (misaligned || is_load) begin
            accept_data = '0;
        end
    end

    always_comb begin
        rdata_shifted = bus.dmem_rdata_i >> {lane_q, 3'b000};
        load_data     = rdata_shifted;
        unique case (funct3_q)
            3'b000:  load_data = {{(BITSIZE-8){rdata_shifted[7]}}, rdata_shifted[7:0]};
            3'b001:  load_data = {{(BITSIZE-16){rdata_shifted[15]}}, rdata_shifted[15:0]};
            3'b100:  load_data = {{(BITSIZE-8){1'b0}}, rdata_shifted[7:0]};
            3'b101:  load_data = {{(BITSIZE-16){1'b0}}, rdata_shifted[15:0]};
            default: load_data = rdata_shifted;
        endcase
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            IDLE: begin
                if (bus.EX_MEM_give_i) begin
                    state_d = mem_access ? REQ : GIVE;
                end
            end
            REQ: begin
                if (bus.dmem_valid_i) begin
                    state_d = GIVE;
                end
            end
            GIVE: begin
                if (bus.WB_MEM_get_i) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments only, so every register
    // samples pre-edge values regardless of process ordering.
    always_ff @(posedge clk or negedge resetn_i) begin
        if (!resetn_i) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_ff @(posedge clk or negedge resetn_i) begin
        if (!resetn_i) begin
            instr_q      <= '0;
            pc_q         <= '0;
            data_q       <= '0;
            misaligned_q <= 1'b0;
            is_load_q    <= 1'b0;
            funct3_q     <= '0;
            lane_q       <= '0;
            we_q         <= 1'b0;
            addr_q       <= '0;
            be_q         <= '0;
            wdata_q      <= '0;
        end else if (accept) begin
            instr_q      <= bus.EX_MEM_instruction_i;
            pc_q         <= bus.EX_MEM_pc_i;
            data_q       <= accept_data;
            misaligned_q <= misaligned;
            is_load_q    <= is_load && mem_access;
            funct3_q     <= funct3;
            lane_q       <= lane;
            // Memory bus registers only move for real accesses, keeping the port quiet otherwise
            if (mem_access) begin
                we_q    <= is_store;
                addr_q  <= {bus.EX_MEM_result_i[BITSIZE-1:2], 2'b00};
                be_q    <= be;
                wdata_q <= is_store ? wdata : '0;
            end
        end else if ((state_q == REQ) && bus.dmem_valid_i && is_load_q) begin
            data_q <= load_data;
        end
    end

    assign bus.MEM_EX_get_o         = (state_q == IDLE);
    assign bus.dmem_req_o           = (state_q == REQ);
    assign bus.dmem_we_o            = we_q;
    assign bus.dmem_addr_o          = addr_q;
    assign bus.dmem_be_o            = be_q;
    assign bus.dmem_wdata_o         = wdata_q;
    assign bus.MEM_WB_give_o        = (state_q == GIVE);
    assign bus.MEM_WB_instruction_o = instr_q;
    assign bus.MEM_WB_pc_o          = pc_q;
    assign bus.MEM_WB_data_o        = data_q;
    assign bus.MEM_WB_misaligned_o  = misaligned_q;

endmodule

// File: tb/tb_mem_stage.sv
// Directed bench for mem_stage: a transaction-level model predicts each instruction's
// memory access and writeback payload; a monitor compares them on every falling edge.
module tb_mem_stage;

    logic clk;
    logic resetn;
    int   errors;
    int   checks;

    mem_stage_if #(.BITSIZE(32)) bus ();

    mem_stage #(.BITSIZE(32)) dut (
        .clk      (clk),
        .resetn_i (resetn),
        .bus      (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct packed {
        logic        mem;
        logic        we;
        logic        mis;
        logic [3:0]  be;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [31:0] data;
        logic [31:0] instr;
        logic [31:0] pc;
    } exp_t;

    exp_t exp_cur;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, req, $time);
        end
    endtask

    function automatic logic [31:0] mk(input logic [6:0] op, input logic [2:0] f3);
        return {17'd0, f3, 5'd1, op};
    endfunction

    // Outcome of one instruction derived from address arithmetic on byte counts
    function automatic exp_t model(input logic [31:0] instr, input logic [31:0] pc,
                                   input logic [31:0] res, input logic [31:0] rs2,
                                   input logic [31:0] rdata);
        exp_t        m;
        int          f3;
        int          a;
        int          nb;
        logic        ld;
        logic        st;
        logic [31:0] mask;
        logic [31:0] v;
        m       = '0;
        m.instr = instr;
        m.pc    = pc;
        m.data  = res;
        f3      = int'(instr[14:12]);
        a       = int'(res % 32'd4);
        ld      = (instr[6:0] == 7'h03) && (f3 != 3) && (f3 <= 5);
        st      = (instr[6:0] == 7'h23) && (f3 <= 2);
        nb      = 1 << (f3 % 4);
        if (ld || st) begin
            if ((a % nb) != 0) begin
                m.mis  = 1'b1;
                m.data = 32'd0;
            end else begin
                m.mem  = 1'b1;
                m.we   = st;
                m.addr = res - 32'(a);
                m.be   = 4'(((1 << nb) - 1) << a);
                if (st) begin
                    if (nb == 1)      m.wdata = rs2[7:0] * 32'h0101_0101;
                    else if (nb == 2) m.wdata = rs2[15:0] * 32'h0001_0001;
                    else              m.wdata = rs2;
                    m.data = res;
                end else begin
                    mask = (nb == 4) ? 32'hFFFF_FFFF : ((32'd1 << (8 * nb)) - 32'd1);
                    v    = (rdata >> (8 * a)) & mask;
                    if (f3 < 4 && nb < 4 && v[8 * nb - 1]) v = v | ~mask;
                    m.data = v;
                end
            end
        end
        return m;
    endfunction

    // Continuous comparison of whatever the DUT is currently presenting
    always @(negedge clk) begin
        if (resetn) begin
            if (bus.dmem_req_o) begin
                check("req_expected", 32'(exp_cur.mem), 32'd1);
                check("dmem_we", 32'(bus.dmem_we_o), 32'(exp_cur.we));
                check("dmem_addr", bus.dmem_addr_o, exp_cur.addr);
                check("dmem_be", 32'(bus.dmem_be_o), 32'(exp_cur.be));
                if (exp_cur.we) check("dmem_wdata", bus.dmem_wdata_o, exp_cur.wdata);
            end
            if (bus.MEM_WB_give_o) begin
                check("wb_instr", bus.MEM_WB_instruction_o, exp_cur.instr);
                check("wb_pc", bus.MEM_WB_pc_o, exp_cur.pc);
                check("wb_data", bus.MEM_WB_data_o, exp_cur.data);
                check("wb_mis", 32'(bus.MEM_WB_misaligned_o), 32'(exp_cur.mis));
            end
        end
    end

    // Offer one instruction at a falling edge; returns just after the accepting edge
    task automatic send(input logic [31:0] instr, input logic [31:0] pc,
                        input logic [31:0] res, input logic [31:0] rs2);
        int cnt;
        bus.EX_MEM_give_i        = 1'b1;
        bus.EX_MEM_instruction_i = instr;
        bus.EX_MEM_pc_i          = pc;
        bus.EX_MEM_result_i      = res;
        bus.EX_MEM_rs2_i         = rs2;
        cnt = 0;
        while (!bus.MEM_EX_get_o && cnt < 20) begin
            @(negedge clk);
            cnt++;
        end
        if (cnt >= 20) check("accept_timeout", 32'd0, 32'd1);
        @(posedge clk);
        #1;
        bus.EX_MEM_give_i = 1'b0;
    endtask

    // Full instruction lifetime with latency, literal payload and backpressure checks
    task automatic do_txn(input string name, input logic [31:0] instr, input logic [31:0] pc,
                          input logic [31:0] res, input logic [31:0] rs2,
                          input logic [31:0] rdata, input int delay,
                          input logic [31:0] lit_data, input logic lit_mis,
                          input logic [3:0] lit_be, input int bp);
        exp_cur          = model(instr, pc, res, rs2, rdata);
        bus.WB_MEM_get_i = (bp == 0);
        send(instr, pc, res, rs2);
        @(negedge clk);
        if (exp_cur.mem) begin
            check({name, "_req_latency"}, 32'(bus.dmem_req_o), 32'd1);
            check({name, "_be"}, 32'(bus.dmem_be_o), 32'(lit_be));
            repeat (delay - 1) @(negedge clk);
            bus.dmem_valid_i = 1'b1;
            bus.dmem_rdata_i = rdata;
            @(negedge clk);
            bus.dmem_valid_i = 1'b0;
            bus.dmem_rdata_i = 32'd0;
        end else begin
            check({name, "_no_req"}, 32'(bus.dmem_req_o), 32'd0);
        end
        check({name, "_give_latency"}, 32'(bus.MEM_WB_give_o), 32'd1);
        check({name, "_data"}, bus.MEM_WB_data_o, lit_data);
        check({name, "_mis"}, 32'(bus.MEM_WB_misaligned_o), 32'(lit_mis));
        for (int i = 0; i < bp; i++) begin
            @(negedge clk);
            check({name, "_stall_give"}, 32'(bus.MEM_WB_give_o), 32'd1);
            check({name, "_stall_get"}, 32'(bus.MEM_EX_get_o), 32'd0);
            check({name, "_stall_data"}, bus.MEM_WB_data_o, lit_data);
        end
        bus.WB_MEM_get_i = 1'b1;
        @(negedge clk);
        check({name, "_give_drop"}, 32'(bus.MEM_WB_give_o), 32'd0);
        check({name, "_get_back"}, 32'(bus.MEM_EX_get_o), 32'd1);
    endtask

    localparam logic [6:0] LD = 7'h03;
    localparam logic [6:0] ST = 7'h23;
    localparam logic [6:0] AL = 7'h33;

    initial begin
        exp_t pin;
        errors                   = 0;
        checks                   = 0;
        exp_cur                  = '0;
        resetn                   = 1'b0;
        bus.EX_MEM_give_i        = 1'b0;
        bus.EX_MEM_instruction_i = '0;
        bus.EX_MEM_pc_i          = '0;
        bus.EX_MEM_result_i      = '0;
        bus.EX_MEM_rs2_i         = '0;
        bus.dmem_rdata_i         = '0;
        bus.dmem_valid_i         = 1'b0;
        bus.WB_MEM_get_i         = 1'b1;

        // Hand-computed values that pin the model itself
        pin = model(mk(LD, 3'b000), 32'h0, 32'h103, 32'h0, 32'h80FF_0000);
        check("model_lb_data", pin.data, 32'hFFFF_FF80);
        check("model_lb_be", 32'(pin.be), 32'h8);
        pin = model(mk(ST, 3'b001), 32'h0, 32'h202, 32'hDEAD_BEEF, 32'h0);
        check("model_sh_wdata", pin.wdata, 32'hBEEF_BEEF);
        check("model_sh_addr", pin.addr, 32'h200);
        pin = model(mk(LD, 3'b010), 32'h0, 32'h305, 32'h0, 32'h0);
        check("model_lw_mis", 32'(pin.mis), 32'd1);

        @(negedge clk);
        check("rst_get", 32'(bus.MEM_EX_get_o), 32'd1);
        check("rst_give", 32'(bus.MEM_WB_give_o), 32'd0);
        check("rst_req", 32'(bus.dmem_req_o), 32'd0);
        check("rst_data", bus.MEM_WB_data_o, 32'd0);
        #2 resetn = 1'b1;
        @(negedge clk);

        do_txn("add",  mk(AL, 3'b000), 32'h1000, 32'h0000_1234, 32'h0, 32'h0, 0,
               32'h0000_1234, 1'b0, 4'h0, 0);
        do_txn("lb",   mk(LD, 3'b000), 32'h1004, 32'h0000_0103, 32'h0, 32'h80FF_0000, 3,
               32'hFFFF_FF80, 1'b0, 4'b1000, 0);
        do_txn("lbu",  mk(LD, 3'b100), 32'h1008, 32'h0000_0103, 32'h0, 32'h80FF_0000, 3,
               32'h0000_0080, 1'b0, 4'b1000, 0);
        do_txn("sh",   mk(ST, 3'b001), 32'h100C, 32'h0000_0202, 32'hDEAD_BEEF, 32'h0, 2,
               32'h0000_0202, 1'b0, 4'b1100, 0);
        do_txn("lwmis", mk(LD, 3'b010), 32'h1010, 32'h0000_0305, 32'h0, 32'h0, 0,
               32'h0, 1'b1, 4'h0, 0);
        do_txn("lw_bp", mk(LD, 3'b010), 32'h1014, 32'h0000_0400, 32'h0, 32'h1234_5678, 1,
               32'h1234_5678, 1'b0, 4'b1111, 5);
        do_txn("lh",   mk(LD, 3'b001), 32'h1018, 32'h0000_0002, 32'h0, 32'h8001_0000, 1,
               32'hFFFF_8001, 1'b0, 4'b1100, 0);
        do_txn("lhu",  mk(LD, 3'b101), 32'h101C, 32'h0000_0002, 32'h0, 32'h8001_0000, 2,
               32'h0000_8001, 1'b0, 4'b1100, 0);
        do_txn("sb",   mk(ST, 3'b000), 32'h1020, 32'h0000_0001, 32'h0000_00A5, 32'h0, 1,
               32'h0000_0001, 1'b0, 4'b0010, 0);
        do_txn("badf3", mk(LD, 3'b011), 32'h1024, 32'h0000_0777, 32'h0, 32'h0, 0,
               32'h0000_0777, 1'b0, 4'h0, 0);
        do_txn("swmis", mk(ST, 3'b010), 32'h1028, 32'h0000_0102, 32'h5555_AAAA, 32'h0, 0,
               32'h0, 1'b1, 4'h0, 0);
        do_txn("lhmis", mk(LD, 3'b001), 32'h102C, 32'h0000_0003, 32'h0, 32'h0, 0,
               32'h0, 1'b1, 4'h0, 0);

        // Asynchronous reset while a request is outstanding
        exp_cur = model(mk(LD, 3'b010), 32'h2000, 32'h0000_0400, 32'h0, 32'h0);
        send(mk(LD, 3'b010), 32'h2000, 32'h0000_0400, 32'h0);
        @(negedge clk);
        check("rreq_pre", 32'(bus.dmem_req_o), 32'd1);
        #2 resetn = 1'b0;
        #1;
        check("rreq_async_drop", 32'(bus.dmem_req_o), 32'd0);
        check("rreq_get", 32'(bus.MEM_EX_get_o), 32'd1);
        check("rreq_addr", bus.dmem_addr_o, 32'd0);
        @(negedge clk);
        #2 resetn = 1'b1;
        @(negedge clk);
        bus.dmem_valid_i = 1'b1;
        bus.dmem_rdata_i = 32'hCAFE_F00D;
        @(negedge clk);
        bus.dmem_valid_i = 1'b0;
        bus.dmem_rdata_i = 32'd0;
        check("stray_valid_give", 32'(bus.MEM_WB_give_o), 32'd0);
        check("stray_valid_req", 32'(bus.dmem_req_o), 32'd0);
        check("stray_valid_get", 32'(bus.MEM_EX_get_o), 32'd1);
        do_txn("post_rst", mk(LD, 3'b000), 32'h2004, 32'h0000_0010, 32'h0, 32'h0000_007F, 1,
               32'h0000_007F, 1'b0, 4'b0001, 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
